yarp_fetch_unit: RTL
====================

YARP_FETCH_UNIT -- requirements
Module: yarp_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h1000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving prefetch FIFO entries; it must be a power of two and at least 2.
REQ-003 The block SHALL have parameter MAX_OUTST, default 2, giving the maximum granted-but-unanswered requests; it must be at most DEPTH.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- instr_mem_req_o  out  1  fetch request.
- instr_mem_addr_o  out  32  word-aligned fetch address.
- instr_mem_gnt_i  in  1  request accepted this cycle.
- instr_mem_rvalid_i  in  1  response data valid; responses return in grant order.
- instr_mem_rd_data_i  in  32  response instruction.
- redirect_i  in  1  branch/jump redirect.
- redirect_pc_i  in  32  redirect target.
- instr_valid_o  out  1  FIFO head valid.
- instr_o  out  32  head instruction.
- instr_pc_o  out  32  head instruction PC.
- instr_ready_i  in  1  consumer accepts head.
- fifo_count_o  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-005 Request rule: instr_mem_req_o SHALL be 1 only when state=RUN, redirect_i=0, outst<MAX_OUTST, and count+outst<DEPTH.
REQ-006 Address: instr_mem_addr_o SHALL equal fetch_pc.
- fetch_pc advances by 4 (mod 2^32) only on req&gnt.
- Address stays stable while req=1 and gnt=0.
REQ-007 Outstanding counter: outst SHALL increment on req&gnt and decrement on rvalid; both in the same cycle leaves it unchanged.
REQ-008 Response in RUN: the block SHALL push {resp_pc, rd_data} into the FIFO and advance resp_pc by 4.
- Latency: instr_valid_o=1 in the cycle after rvalid at the earliest.
REQ-009 Consumer handshake: instr_valid_o SHALL equal (count!=0), with instr_o/instr_pc_o from the FIFO head.
- Pop on valid&ready.
- Outputs hold stable while valid=1 and ready=0.
REQ-010 Simultaneous push and pop SHALL leave count unchanged, including when count=DEPTH.
- The credit rule of REQ-005 guarantees no push is ever lost.
REQ-011 Redirect (any state) SHALL, next cycle:
- empty the FIFO;
- set fetch_pc and resp_pc to {redirect_pc_i[31:2],2'b00};
- set drop = outst minus the rvalid of the redirect cycle.
REQ-012 Redirect state transition: the next state SHALL be RUN if drop=0, else FLUSH.
REQ-013 FLUSH SHALL behave as follows:
- req_o=0.
- Each rvalid decrements drop and outst, and its data is discarded.
- On the cycle drop reaches 0, the next state is RUN.
REQ-014 A redirect during FLUSH SHALL overwrite fetch_pc and resp_pc; drop continues counting the still-pending responses.
REQ-015 redirect_i and a pop in the same cycle: the flush SHALL take priority; the pop is still acknowledged, but no head survives.
REQ-016 An rvalid with outst=0 SHALL be ignored and SHALL NOT be pushed, as a protocol error.

Reset
REQ-017 While reset=1 at a clock edge, the block SHALL set:
- fetch_pc=resp_pc=RESET_PC;
- count=0, outst=0, drop=0;
- state=RUN.
REQ-018 Outputs during and after reset SHALL be: instr_mem_req_o=0 while reset=1; instr_valid_o=0; fifo_count_o=0; instr_mem_addr_o=RESET_PC.
- The first request is asserted in the first cycle with reset=0.
REQ-019 Reset mid-operation SHALL discard all FIFO contents and pending responses; responses arriving after reset fall under REQ-016.

Structure
REQ-020 Package yarp_pkg SHALL hold typedef enum yarp_fetch_state_t {FETCH_RUN, FETCH_FLUSH} and constant YARP_INSTR_BYTES=4.
REQ-021 The FIFO SHALL be one sub-module, yarp_fifo, with parameters WIDTH (64 here: {pc,instr}) and DEPTH.
- Ports: push/pop/flush/full/empty/count.
- Same clk and synchronous active-high reset.

Verification
REQ-022 Reset, gnt=1, rvalid one cycle after each gnt, ready=1 SHALL produce:
- addresses 0x1000, 0x1004, 0x1008 on consecutive cycles;
- instr_pc_o 0x1000 first, valid two cycles after the first gnt.
REQ-023 ready=0, gnt=1, DEPTH=4 SHALL give count=4 after four responses, then req_o=0.
- Raising ready for one cycle SHALL give exactly one further request.
REQ-024 Redirect to 0x2002 with outst=2 SHALL give:
- FIFO empty next cycle;
- state FLUSH, with the next two rvalid discarded;
- first new address 0x2000;
- first delivered instr_pc_o 0x2000.
REQ-025 A redirect to 0x3000 in the same cycle as the final FLUSH rvalid, then 0x4000 one cycle later, SHALL make 0x4000 the only new address fetched.
REQ-026 gnt=0 for 5 cycles with req=1 SHALL keep addr 0x1000 constant and outst=0.
- Asserting reset mid-stream with 3 entries valid SHALL give count=0 and valid=0 the next cycle.

Source files
------------

// File: rtl/yarp_pkg.sv
// Shared types and constants for the YARP instruction fetch unit.
package yarp_pkg;

  // RUN issues fetches; FLUSH waits out responses that belong to a stale stream.
  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_FLUSH = 1'b1
  } yarp_fetch_state_t;

  // Every instruction is one 32-bit word.
  localparam int YARP_INSTR_BYTES = 4;

endpackage

// File: rtl/yarp_fifo.sv
// Prefetch FIFO: circular buffer with synchronous flush, occupancy count and
// first-word-fall-through head. Push and pop may happen in the same cycle
// even when full, because the pop frees the slot the push is about to use.
module yarp_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_data = mem[rd_ptr];

  // A flush discards everything, including anything offered in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/yarp_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches under a credit rule
// (outstanding + buffered never exceeds the FIFO depth), buffers responses
// with their PCs, and handles redirects by flushing the FIFO and dropping
// responses still in flight for the abandoned stream.
//
// Handshakes: a fetch is taken when instr_mem_req_o & instr_mem_gnt_i in the
// same cycle; the address holds while req is high and gnt low. An instruction
// is consumed when instr_valid_o & instr_ready_i; head data holds while valid
// is high and ready low. Responses (instr_mem_rvalid_i) return in grant order
// and need no ready.
module yarp_fetch_unit
  import yarp_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h1000,
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       instr_mem_req_o,
  output logic [31:0]                instr_mem_addr_o,
  input  logic                       instr_mem_gnt_i,
  input  logic                       instr_mem_rvalid_i,
  input  logic [31:0]                instr_mem_rd_data_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic                       instr_valid_o,
  output logic [31:0]                instr_o,
  output logic [31:0]                instr_pc_o,
  input  logic                       instr_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

  localparam int OW = $clog2(MAX_OUTST+1);

  yarp_fetch_state_t state;
  yarp_fetch_state_t state_next;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [OW-1:0] outst;
  logic [OW-1:0] drop;

  logic          rsp_ok;
  logic          fire;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          credit_ok;
  logic [OW-1:0] outst_after_rsp;
  logic [31:0]   target_pc;
  logic [63:0]   head;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok          = instr_mem_rvalid_i & (outst != '0);
  assign fire            = instr_mem_req_o & instr_mem_gnt_i;
  assign push            = (state == FETCH_RUN) & ~redirect_i & rsp_ok;
  assign pop             = instr_valid_o & instr_ready_i;
  assign outst_after_rsp = outst - OW'(rsp_ok);
  assign target_pc       = redirect_pc_i & ~32'h3;

  // Every granted request must already own a FIFO slot, so pushes never stall.
  assign credit_ok = ~fifo_full
                   & (int'(outst) < MAX_OUTST)
                   & ((int'(fifo_count_o) + int'(outst)) < DEPTH);

  assign instr_mem_addr_o = fetch_pc;
  assign instr_valid_o    = ~fifo_empty;
  assign instr_pc_o       = head[63:32];
  assign instr_o          = head[31:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH_RUN;
    else       state <= state_next;
  end

  // FSM next state: a redirect only needs FLUSH if stale responses remain.
  always_comb begin
    state_next = state;
    if (redirect_i) begin
      state_next = (outst_after_rsp == '0) ? FETCH_RUN : FETCH_FLUSH;
    end else if (state == FETCH_FLUSH) begin
      if (drop == '0 || (rsp_ok && drop == OW'(1))) state_next = FETCH_RUN;
    end
  end

  // FSM output: request only in RUN, outside reset/redirect, with credit.
  always_comb begin
    instr_mem_req_o = 1'b0;
    if (state == FETCH_RUN && !reset && !redirect_i && credit_ok) instr_mem_req_o = 1'b1;
  end

  // Fetch and response PCs; both restart at the aligned redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= target_pc;
      resp_pc  <= target_pc;
    end else begin
      if (fire) fetch_pc <= fetch_pc + 32'(YARP_INSTR_BYTES);
      if (push) resp_pc  <= resp_pc + 32'(YARP_INSTR_BYTES);
    end
  end

  // Outstanding and to-be-dropped response counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      outst <= '0;
      drop  <= '0;
    end else begin
      outst <= outst + OW'(fire) - OW'(rsp_ok);
      if (redirect_i)                                       drop <= outst_after_rsp;
      else if (state == FETCH_FLUSH && rsp_ok && drop != '0) drop <= drop - 1'b1;
    end
  end

  yarp_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({resp_pc, instr_mem_rd_data_i}),
    .pop       (pop),
    .flush     (redirect_i),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_o)
  );

endmodule
